// File: rtl/spi_ram_pkg.sv
// Command encodings and controller states shared by the SPI RAM master and its serializer.
// Frames are {cmd[1:0], payload}, sent MSB first.
package spi_ram_pkg;

  typedef logic [1:0] cmd_t;

  localparam cmd_t CMD_WR_ADDR = 2'b00;
  localparam cmd_t CMD_WR_DATA = 2'b01;
  localparam cmd_t CMD_RD_ADDR = 2'b10;
  localparam cmd_t CMD_RD_DATA = 2'b11;

  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SHIFT = 3'd2,
    TURN  = 3'd3,
    RECV  = 3'd4,
    GAP   = 3'd5
  } state_t;

  // Command of the first (address) or second (data) frame of a request.
  function automatic cmd_t frame_cmd(input logic wr, input logic second);
    cmd_t c;
    if (wr) begin
      c = second ? CMD_WR_DATA : CMD_WR_ADDR;
    end else begin
      c = second ? CMD_RD_DATA : CMD_RD_ADDR;
    end
    return c;
  endfunction

endpackage

// File: rtl/spi_ram_frame_ser.sv
// Transmit shift register with registered MOSI, plus the MSB-first receive register.
// The MSB of a loaded frame goes straight to MOSI, so the register only keeps the rest.
module spi_ram_frame_ser #(
  parameter int unsigned FW = 10,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [FW-1:0] frame,
  input  logic          shift,
  input  logic          clr,
  input  logic          sample,
  input  logic          miso,
  output logic          mosi,
  output logic [DW-1:0] rx_next
);

  logic [FW-2:0] sh_q, sh_d;
  logic          mosi_q, mosi_d;
  logic [DW-1:0] rx_q, rx_d;

  // Next-state for the transmit and receive registers.
  always_comb begin
    sh_d    = sh_q;
    mosi_d  = mosi_q;
    rx_next = {rx_q[DW-2:0], miso};
    if (load) begin
      sh_d   = frame[FW-2:0];
      mosi_d = frame[FW-1];
    end else if (shift) begin
      sh_d   = {sh_q[FW-3:0], 1'b0};
      mosi_d = sh_q[FW-2];
    end else if (clr) begin
      mosi_d = 1'b0;
    end else begin
      mosi_d = mosi_q;
    end
    if (sample) begin
      rx_d = rx_next;
    end else begin
      rx_d = rx_q;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= {(FW-1){1'b0}};
      mosi_q <= 1'b0;
      rx_q   <= {DW{1'b0}};
    end else begin
      sh_q   <= sh_d;
      mosi_q <= mosi_d;
      rx_q   <= rx_d;
    end
  end

  assign mosi = mosi_q;

endmodule

// File: rtl/spi_ram_master.sv
// SPI master that turns host read/write requests into two-frame transactions to a SPI RAM.
// All outputs are registered from the next-state values, so they line up with the state they describe.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [ADDR_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int unsigned FW = ADDR_SIZE + 2;
  localparam logic [CNT_W-1:0] SHIFT_LAST = 5'(FW - 1);
  localparam logic [CNT_W-1:0] RECV_LAST  = 5'(ADDR_SIZE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = 5'(GAP_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 phase_q, phase_d;
  logic                 wr_q, wr_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ADDR_SIZE-1:0] wdata_q, wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ADDR_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 req_ready_q, req_ready_d;
  logic                 busy_q, busy_d;
  logic                 ss_n_q, ss_n_d;

  cmd_t                 cur_cmd_s;
  logic [ADDR_SIZE-1:0] payload_s;
  logic [FW-1:0]        frame_s;
  logic                 ser_load_s, ser_shift_s, ser_clr_s, ser_sample_s;
  logic [ADDR_SIZE-1:0] rx_next_s;
  logic                 mosi_s;

  spi_ram_frame_ser #(
    .FW (FW),
    .DW (ADDR_SIZE)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (ser_load_s),
    .frame   (frame_s),
    .shift   (ser_shift_s),
    .clr     (ser_clr_s),
    .sample  (ser_sample_s),
    .miso    (MISO),
    .mosi    (mosi_s),
    .rx_next (rx_next_s)
  );

  // Sequencing: next state, counters, request latch and serializer controls.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    ser_load_s   = 1'b0;
    ser_shift_s  = 1'b0;
    ser_clr_s    = 1'b0;
    ser_sample_s = 1'b0;
    cur_cmd_s    = frame_cmd(wr_q, phase_q);

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          wr_d       = req_wr;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          phase_d    = 1'b0;
          cnt_d      = 5'd0;
          state_d    = START;
          ser_load_s = 1'b1;
        end else begin
          ser_clr_s = 1'b1;
        end
      end
      START: begin
        cnt_d   = 5'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          cnt_d     = 5'd0;
          ser_clr_s = 1'b1;
          if (cur_cmd_s == CMD_RD_DATA) begin
            state_d = TURN;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d       = cnt_q + 5'd1;
          ser_shift_s = 1'b1;
        end
      end
      TURN: begin
        cnt_d   = 5'd0;
        state_d = RECV;
      end
      RECV: begin
        ser_sample_s = 1'b1;
        if (cnt_q == RECV_LAST) begin
          rsp_rdata_d = rx_next_s;
          rsp_valid_d = 1'b1;
          cnt_d       = 5'd0;
          state_d     = GAP;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = 5'd0;
          if (!phase_q) begin
            phase_d    = 1'b1;
            state_d    = START;
            ser_load_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        cnt_d   = 5'd0;
        state_d = IDLE;
      end
    endcase

    // The frame is built from the post-accept values so the first frame loads on the accept edge.
    if (phase_d) begin
      payload_s = wr_d ? wdata_d : {ADDR_SIZE{1'b0}};
    end else begin
      payload_s = addr_d;
    end
    frame_s = {frame_cmd(wr_d, phase_d), payload_s};

    ss_n_d      = !((state_d == START) || (state_d == SHIFT) ||
                    (state_d == TURN)  || (state_d == RECV));
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset wins over everything and discards a latched request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      phase_q     <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= {ADDR_SIZE{1'b0}};
      wdata_q     <= {ADDR_SIZE{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {ADDR_SIZE{1'b0}};
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      ss_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      ss_n_q      <= ss_n_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_s;

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: a behavioural SPI RAM slave, frame/response scoreboards,
// a request table, and hand sequences for back-to-back traffic, mid-frame reset and GAP_CYCLES=1.
module tb_spi_ram_master;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_wr;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy, SS_n, MOSI, MISO;

  logic       req_valid1, req_ready1, req_wr1;
  logic [7:0] req_addr1, req_wdata1;
  logic       rsp_valid1;
  logic [7:0] rsp_rdata1;
  logic       busy1, SS_n1, MOSI1;
  logic       MISO1 = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] exp_frames[$];
  logic [7:0] exp_rsp[$];

  always #5 clk = ~clk;

  spi_ram_master #(.ADDR_SIZE(8), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO));

  spi_ram_master #(.ADDR_SIZE(8), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_wr(req_wr1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
    .busy(busy1), .SS_n(SS_n1), .MOSI(MOSI1), .MISO(MISO1));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Behavioural SPI RAM slave: samples MOSI and drives MISO on the falling edge.
  logic [7:0] mem [256];
  int         sl_cnt = 0;
  int         hi_cnt = 0;
  bit         seen_frame = 1'b0;
  logic [9:0] sl_sh;
  logic       sl_start;
  logic [7:0] sl_addr;
  logic [9:0] efr;

  always @(negedge clk) begin
    if (rst) begin
      sl_cnt = 0; hi_cnt = 0; seen_frame = 1'b0; MISO = 1'b0;
    end else if (!SS_n) begin
      if (sl_cnt == 0 && seen_frame) check("gap_len_ok", 32'(hi_cnt >= GAP), 32'd1);
      hi_cnt = 0;
      if (sl_cnt == 0) sl_start = MOSI;
      else if (sl_cnt <= 10) sl_sh = {sl_sh[8:0], MOSI};
      else if (sl_cnt == 11 && sl_sh[9:8] == 2'b11) check("turn_mosi", 32'(MOSI), 32'd0);
      if (sl_cnt >= 12 && sl_cnt <= 19 && sl_sh[9:8] == 2'b11) MISO = mem[sl_addr][19 - sl_cnt];
      sl_cnt++;
    end else begin
      if (sl_cnt != 0) begin
        seen_frame = 1'b1;
        check("frame_len", 32'(sl_cnt), (sl_sh[9:8] == 2'b11) ? 32'd20 : 32'd11);
        check("start_bit", 32'(sl_start), 32'(sl_sh[9]));
        if (exp_frames.size() == 0) begin
          fail_now("unexpected_frame");
        end else begin
          efr = exp_frames.pop_front();
          check("frame", 32'(sl_sh), 32'(efr));
        end
        case (sl_sh[9:8])
          2'b00, 2'b10: sl_addr = sl_sh[7:0];
          2'b01:        mem[sl_addr] = sl_sh[7:0];
          default:      ;
        endcase
      end
      check("idle_mosi", 32'(MOSI), 32'd0);
      sl_cnt = 0; MISO = 1'b0; hi_cnt++;
    end
  end

  // Response monitor: one-cycle pulse, coincident with SS_n rising, data from the scoreboard.
  logic ss_prev = 1'b1;
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_rsp.size() == 0) fail_now("unexpected_rsp");
      else check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rsp.pop_front()));
      check("rsp_with_ss_rise", 32'({ss_prev, SS_n}), 32'b01);
      check("rsp_one_cycle", 32'(rv_prev), 32'd0);
    end
    ss_prev = SS_n;
    rv_prev = rsp_valid;
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) fail_now("ready_timeout");
  endtask

  task automatic push_exp(input bit wr, input logic [7:0] a, input logic [7:0] d, input logic [7:0] ex);
    if (wr) begin
      exp_frames.push_back({2'b00, a});
      exp_frames.push_back({2'b01, d});
    end else begin
      exp_frames.push_back({2'b10, a});
      exp_frames.push_back({2'b11, 8'h00});
      exp_rsp.push_back(ex);
    end
  endtask

  // One request: accept, then measure cycles to req_ready and to rsp_valid.
  task automatic run_req(input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] ex, input int exp_lat);
    int lat = 0;
    int rsp_at = -1;
    bit busy_ok = 1'b1;
    wait_ready();
    req_wr = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
    push_exp(wr, a, d, ex);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("accept_ready_busy", 32'({req_ready, busy}), 32'b01);
    while (lat < 200) begin
      @(posedge clk); #1; lat++;
      if (rsp_valid) rsp_at = lat;
      if (req_ready) break;
      if (!busy) busy_ok = 1'b0;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_time", 32'(rsp_at), wr ? 32'hFFFF_FFFF : 32'(exp_lat - GAP));
    check("busy_held", 32'(busy_ok), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
  endtask

  task automatic lat1(input bit wr, input int exp_lat);
    int lat = 0;
    req_wr1 = wr; req_addr1 = 8'h3C; req_wdata1 = 8'h11; req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    while (lat < 200) begin
      @(posedge clk); #1; lat++;
      if (req_ready1) break;
    end
    check(wr ? "gap1_wr_latency" : "gap1_rd_latency", 32'(lat), 32'(exp_lat));
    check("gap1_ss_idle", 32'(SS_n1), 32'd1);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    int         exp_lat;
  } vec_t;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  end

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   n_acc;
    int   k;
    bit   acc;
    bit   rv_seen;
    logic [7:0] last_wd;

    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 8'h00, 26};
    vecs[1] = '{1'b0, 8'h3C, 8'h00, 8'hA5, 35};
    vecs[2] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 26};
    vecs[3] = '{1'b1, 8'h00, 8'h00, 8'h00, 26};
    vecs[4] = '{1'b0, 8'hFF, 8'h00, 8'hFF, 35};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 8'h00, 35};
    vecs[6] = '{1'b1, 8'h5A, 8'hC3, 8'h00, 26};
    vecs[7] = '{1'b0, 8'h5A, 8'h00, 8'hC3, 35};

    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    req_valid1 = 1'b0; req_wr1 = 1'b0; req_addr1 = 8'h00; req_wdata1 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss_n", 32'(SS_n), 32'd1);
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      run_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_lat);

    // Back-to-back: req_valid held for 100 cycles, alternating write/read-back.
    wait_ready();
    n_acc = 0; k = 0; last_wd = 8'h00;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h40; req_wdata = 8'h21;
    for (int c = 0; c < 100; c++) begin
      acc = req_ready;
      if (acc) begin
        push_exp(req_wr, req_addr, req_wdata, last_wd);
        if (req_wr) last_wd = req_wdata;
        n_acc++;
      end
      @(posedge clk); #1;
      if (acc) begin
        k++;
        req_wr = (k % 2 == 0);
        req_addr = 8'h40 + 8'(k / 2);
        req_wdata = 8'(8'h21 * (k + 1));
      end
    end
    req_valid = 1'b0;
    wait_ready();
    repeat (4) @(posedge clk);
    #1;
    check("burst_accepts", 32'(n_acc), 32'd4);
    check("burst_frames_left", 32'(exp_frames.size()), 32'd0);
    check("burst_rsp_left", 32'(exp_rsp.size()), 32'd0);

    // Reset during the 5th SHIFT cycle of a read aborts it without a response.
    wait_ready();
    req_wr = 1'b0; req_addr = 8'h3C; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ss_n", 32'(SS_n), 32'd1);
    check("abort_ready_busy", 32'({req_ready, busy}), 32'b10);
    rv_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) rv_seen = 1'b1;
    end
    check("abort_no_rsp", 32'(rv_seen), 32'd0);
    run_req(1'b0, 8'h3C, 8'h00, 8'hA5, 35);
    repeat (4) @(posedge clk);
    #1;
    check("final_frames_left", 32'(exp_frames.size()), 32'd0);
    check("final_rsp_left", 32'(exp_rsp.size()), 32'd0);

    lat1(1'b1, 24);
    lat1(1'b0, 33);
    check("gap1_rdata", 32'(rsp_rdata1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_ram_master.md
SPI_RAM_MASTER -- requirements
Module: spi_ram_master

Interface
REQ-001 Parameter ADDR_SIZE, default 8, SHALL set the RAM address and data width; frame width SHALL be ADDR_SIZE+2.
REQ-002 Parameter GAP_CYCLES, default 2, SHALL set the minimum number of SS_n-high cycles between frames (legal range 1..15).
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  host request present.
REQ-006 req_ready  output  1  controller idle; a request is accepted when req_valid and req_ready are both high on an edge.
REQ-007 req_wr  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_SIZE  RAM address.
REQ-009 req_wdata  input  ADDR_SIZE  write data; ignored for reads.
REQ-010 rsp_valid  output  1  one-cycle pulse marking rsp_rdata valid.
REQ-011 rsp_rdata  output  ADDR_SIZE  read data; held until the next rsp_valid.
REQ-012 busy  output  1  high from request acceptance until return to IDLE.
REQ-013 SS_n  output  1  slave select to the SPI slave/RAM wrapper, active low.
REQ-014 MOSI  output  1  serial data to the slave, MSB first.
REQ-015 MISO  input  1  serial read data from the slave, MSB first.

Function
REQ-016 Frame format SHALL be {cmd[1:0], payload[ADDR_SIZE-1:0]}: cmd 00 = write address, 01 = write data, 10 = read address, 11 = read data.
REQ-017 Write request SHALL issue frame {00,addr}, a gap, frame {01,wdata}, and a gap.
REQ-018 Read request SHALL issue frame {10,addr}, a gap, frame {11,8'h00}, then receive ADDR_SIZE bits, and a gap.
REQ-019 The FSM SHALL have states IDLE, START, SHIFT, TURN, RECV, and GAP.
REQ-020 IDLE: SS_n=1, MOSI=0, req_ready=1. On acceptance, latch req_*, set req_ready=0, and go to START.
REQ-021 START: one cycle, SS_n=0, MOSI=frame[MSB] (command-check cycle, not counted as a bit).
REQ-022 SHIFT: exactly ADDR_SIZE+2 cycles, driving frame[MSB] down to frame[0], one bit per clk.
REQ-023 After SHIFT: cmd 11 goes to TURN; all other commands go to GAP.
REQ-024 TURN: one cycle, SS_n=0, MOSI=0, MISO not sampled.
REQ-025 RECV: ADDR_SIZE cycles, SS_n=0, MISO sampled each edge into a shift register, MSB first.
REQ-026 On the edge ending RECV, rsp_rdata SHALL update and rsp_valid SHALL pulse high for exactly one cycle, coincident with SS_n returning high.
REQ-027 GAP: SS_n=1, MOSI=0, lasting GAP_CYCLES cycles. Then go to START for the second frame of the request, or to IDLE after the last frame.
REQ-028 Low time per frame SHALL be 1+(ADDR_SIZE+2) cycles (11 at default), or 1+(ADDR_SIZE+2)+1+ADDR_SIZE for cmd 11 (20 at default).
REQ-029 Default latency from acceptance edge to req_ready high SHALL be 26 cycles for a write and 35 for a read.
REQ-030 req_valid while req_ready=0 SHALL be ignored; there is no queueing and no stall of rsp_valid.
REQ-031 A new request MAY be accepted on the same edge that req_ready is observed high; req_ready SHALL drop on the following cycle.
REQ-032 The bit counter SHALL be 5 bits and SHALL never wrap within a frame; reaching a terminal count is the only way to exit SHIFT or RECV.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 On rst: state=IDLE, SS_n=1, MOSI=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, counters=0.
REQ-035 rst mid-frame SHALL abort the frame: SS_n=1 on the next cycle, no rsp_valid, and the latched request is discarded.
REQ-036 rst SHALL take priority over every other event on the same edge.

Structure
REQ-037 Package spi_ram_pkg SHALL hold the cmd encodings (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA) and the state enumeration.
REQ-038 One sub-module, spi_ram_frame_ser, SHALL implement the load/shift/sample register pair. Sequencing SHALL remain in spi_ram_master.
REQ-039 The top-level test harness SHALL connect SS_n, MOSI, and MISO directly to the existing SPI slave/RAM wrapper.

Verification
REQ-040 After reset, write addr 8'h3C, data 8'hA5 -> MOSI frames 00_0011_1100 and 01_1010_0101, each preceded by a START cycle, with 2 gap cycles.
REQ-041 Read addr 8'h3C after REQ-040 -> frames 10_0011_1100 and 11_0000_0000, then rsp_valid pulse with rsp_rdata=8'hA5, 35 cycles after acceptance.
REQ-042 Hold req_valid high for 100 cycles with alternating wr/rd -> each request accepted only when req_ready=1, and SS_n-high gaps are never shorter than 2 cycles.
REQ-043 Assert rst in the 5th SHIFT cycle of a read -> SS_n=1 next cycle, no rsp_valid; a following read of 8'h3C still returns 8'hA5.
REQ-044 Write 8'hFF to addr 8'hFF, then 8'h00 to addr 8'h00; read both -> rsp_rdata 8'hFF and 8'h00, with no counter wrap at the boundary values.
REQ-045 GAP_CYCLES=1 regression -> write latency 24 cycles and read latency 33 cycles.
